// File: rtl/noc_bridge_pkg.sv
// Types and constants shared by the NoC bridge serial-link blocks.
package noc_bridge_pkg;

    localparam int NumCredNocBridge = 8;

    typedef logic [$clog2(NumCredNocBridge + 1)-1:0] bridge_credit_t;
    typedef logic [31:0]                             flit_data_t;

endpackage

// File: rtl/serial_link_credit_synchronization.sv
// Credit-based flow control for one serial-link direction: tracks send credits
// towards the remote buffer and gathers return credits to piggyback or force out.
module serial_link_credit_synchronization
    import noc_bridge_pkg::*;
#(
    parameter type credit_t         = logic,
    parameter type data_t           = logic,
    parameter int  NumCredits       = NumCredNocBridge,
    parameter int  ForceSendThresh  = NumCredits - 4,
    parameter bit  CredOnlyConsCred = 1'b0
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  data_t   data_i,
    input  logic    data_valid_i,
    output logic    data_ready_o,
    output data_t   data_o,
    output logic    data_valid_o,
    input  logic    data_ready_i,
    output logic    credits_only_packet_o,
    output credit_t credit_send_o,
    input  credit_t credit_rcvd_i,
    input  logic    receive_cred_i,
    input  logic    buffer_queue_out_val_i,
    input  logic    buffer_queue_out_rdy_i,
    input  logic    req_cred_to_buffer_msg,
    input  logic    allow_cred_consume_i,
    input  logic    consume_cred_to_send_i
);

    // Counters are sized from NumCredits so they work even when credit_t is left narrow.
    localparam int CntW = $clog2(NumCredits + 1);
    typedef logic [CntW-1:0] cnt_t;
    typedef logic [CntW:0]   sum_t;
    localparam cnt_t MaxCnt    = cnt_t'(NumCredits);
    localparam cnt_t ThreshCnt = cnt_t'(ForceSendThresh);

    cnt_t avail_q;
    cnt_t avail_d;
    cnt_t pend_q;
    cnt_t pend_d;
    cnt_t rcvd;
    sum_t avail_sum;
    logic can_send;
    logic force_send;
    logic data_send;
    logic cred_send;
    logic consume_one;
    logic pop;

    always_comb begin
        can_send   = (avail_q != '0) | ~req_cred_to_buffer_msg;
        force_send = allow_cred_consume_i & (pend_q >= ThreshCnt)
                   & ~(data_valid_i & can_send)
                   & (~CredOnlyConsCred | (avail_q != '0));

        data_o                = data_i;
        data_valid_o          = (data_valid_i & can_send) | force_send;
        credits_only_packet_o = force_send;
        data_ready_o          = data_ready_i & can_send & ~force_send;
        credit_send_o         = credit_t'(pend_q);
    end

    always_comb begin
        data_send   = data_valid_i & can_send & data_ready_i;
        cred_send   = force_send & data_ready_i;
        consume_one = (data_send & req_cred_to_buffer_msg) | (cred_send & CredOnlyConsCred);
        rcvd        = cnt_t'(credit_rcvd_i);
        avail_sum   = sum_t'(avail_q) - sum_t'(consume_one)
                    + (receive_cred_i ? sum_t'(rcvd) : '0);
        // Over-return by the remote is a protocol error; clamp and let the assertion report it.
        avail_d     = (avail_sum > sum_t'(MaxCnt)) ? MaxCnt : cnt_t'(avail_sum);

        pop    = buffer_queue_out_val_i & buffer_queue_out_rdy_i;
        pend_d = pend_q;
        if (consume_cred_to_send_i) begin
            pend_d = cnt_t'(pop);
        end else if (pop && (pend_q != MaxCnt)) begin
            pend_d = pend_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            avail_q <= MaxCnt;
            pend_q  <= '0;
        end else begin
            avail_q <= avail_d;
            pend_q  <= pend_d;
        end
    end

    avail_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        avail_sum <= sum_t'(MaxCnt));

    avail_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (avail_q == '0) |-> !consume_one);

endmodule

// File: tb/tb_serial_link_credit_synchronization.sv
// Bench for serial_link_credit_synchronization: vector table, directed corner sequences
// and a randomized run against a credit-accounting model.
module tb_serial_link_credit_synchronization;
    import noc_bridge_pkg::*;

    localparam int NC = 8;
    localparam int TH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    flit_data_t     data_i;
    flit_data_t     data_o;
    logic           dv, dro, dvo, dr, cop;
    bridge_credit_t cs, cr;
    logic           rcv, qv, qr, req, allow, cons;

    always #5 clk = ~clk;

    serial_link_credit_synchronization #(
        .credit_t        (bridge_credit_t),
        .data_t          (flit_data_t),
        .NumCredits      (NC),
        .ForceSendThresh (TH),
        .CredOnlyConsCred(1'b0)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .data_i                (data_i),
        .data_valid_i          (dv),
        .data_ready_o          (dro),
        .data_o                (data_o),
        .data_valid_o          (dvo),
        .data_ready_i          (dr),
        .credits_only_packet_o (cop),
        .credit_send_o         (cs),
        .credit_rcvd_i         (cr),
        .receive_cred_i        (rcv),
        .buffer_queue_out_val_i(qv),
        .buffer_queue_out_rdy_i(qr),
        .req_cred_to_buffer_msg(req),
        .allow_cred_consume_i  (allow),
        .consume_cred_to_send_i(cons)
    );

    int total = 0;
    int bad   = 0;
    int m_avail, m_pend;
    int last_dvo, last_dro, last_cop, last_cs, last_hs;

    typedef struct {
        logic dv, dr, pop, allow, cons;
        int   e_dvo, e_dro, e_cop, e_cs;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        dv = 0; dr = 0; qv = 0; qr = 0; rcv = 0; cr = '0;
        req = 1; allow = 0; cons = 0;
        data_i = flit_data_t'($urandom);
    endtask

    // Called at a negedge with inputs applied: check outputs, then advance one clock.
    task automatic cyc();
        bit can, frc, dsend;
        #1;
        can = (m_avail > 0) || !req;
        frc = allow && (m_pend >= TH) && !(dv && can);
        chk("data_valid_o", int'(dvo), int'((dv && can) || frc));
        chk("data_ready_o", int'(dro), int'(dr && can && !frc));
        chk("credits_only", int'(cop), int'(frc));
        chk("credit_send",  int'(cs),  m_pend);
        chk("data_pass",    int'(data_o == data_i), 1);
        last_dvo = int'(dvo); last_dro = int'(dro); last_cop = int'(cop); last_cs = int'(cs);
        last_hs  = int'(dvo && dr);
        $display("cyc t=%0t dv=%0b dr=%0b pop=%0b rcv=%0b/%0d cons=%0b -> dvo=%0b dro=%0b cop=%0b cs=%0d",
                 $time, dv, dr, qv & qr, rcv, cr, cons, dvo, dro, cop, cs);
        dsend = dv && can && dr;
        @(posedge clk);
        if (!rst_n) begin
            m_avail = NC; m_pend = 0;
        end else begin
            if (dsend && req) m_avail = m_avail - 1;
            if (rcv) m_avail = m_avail + int'(cr);
            if (cons) m_pend = int'(qv && qr);
            else if (qv && qr && m_pend < NC) m_pend = m_pend + 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 0; m_avail = NC; m_pend = 0;
        cyc(); cyc();
        rst_n = 1;
    endtask

    task automatic drain(output int n);
        n = 0;
        idle(); dv = 1; dr = 1;
        repeat (12) begin
            cyc();
            if (last_hs != 0) n++;
        end
        idle();
    endtask

    task automatic pops(input int k);
        repeat (k) begin qv = 1; qr = 1; cyc(); end
        qv = 0; qr = 0;
    endtask

    initial begin
        int n;
        tbl[0] = '{0,1,1,1,0, 0,1,0,0};
        tbl[1] = '{0,1,1,1,0, 0,1,0,1};
        tbl[2] = '{0,1,1,1,0, 0,1,0,2};
        tbl[3] = '{1,0,1,1,0, 1,0,0,3};
        tbl[4] = '{1,1,0,1,0, 1,1,0,4};
        tbl[5] = '{0,1,0,0,0, 0,1,0,4};
        tbl[6] = '{0,0,0,1,0, 1,0,1,4};
        tbl[7] = '{0,1,0,1,1, 1,0,1,4};
        tbl[8] = '{0,1,0,1,0, 0,1,0,0};

        idle();
        do_reset();
        // Reset-state behaviour with live inputs held in reset
        @(negedge clk);
        rst_n = 0; allow = 1; dv = 1; dr = 1;
        #1;
        chk("reset_cs",  int'(cs), 0);
        chk("reset_cop", int'(cop), 0);
        chk("reset_dvo", int'(dvo), 1);
        cyc();
        idle();
        rst_n = 1;
        cyc();

        // Vector table
        do_reset();
        foreach (tbl[i]) begin
            idle();
            dv = tbl[i].dv; dr = tbl[i].dr; qv = tbl[i].pop; qr = tbl[i].pop;
            allow = tbl[i].allow; cons = tbl[i].cons;
            cyc();
            chk($sformatf("tbl%0d_dvo", i), last_dvo, tbl[i].e_dvo);
            chk($sformatf("tbl%0d_dro", i), last_dro, tbl[i].e_dro);
            chk($sformatf("tbl%0d_cop", i), last_cop, tbl[i].e_cop);
            chk($sformatf("tbl%0d_cs",  i), last_cs,  tbl[i].e_cs);
        end

        // Eight flits exhaust the credits, the ninth stalls
        do_reset();
        dv = 1; dr = 1;
        for (int i = 0; i < NC; i++) begin
            cyc();
            chk($sformatf("exhaust_hs%0d", i), last_hs, 1);
        end
        cyc();
        chk("exhaust_stall_dvo", last_dvo, 0);
        chk("exhaust_stall_dro", last_dro, 0);

        // Three credits returned at zero: exactly three more flits
        idle(); rcv = 1; cr = 3;
        cyc();
        drain(n);
        chk("return3_flits", n, 3);

        // Four pops force a credit-only packet
        do_reset();
        allow = 1;
        pops(4);
        cyc();
        chk("force_cs",  last_cs, 4);
        chk("force_dvo", last_dvo, 1);
        chk("force_cop", last_cop, 1);
        dr = 1; cons = 1;
        cyc();
        chk("force_hs", last_hs, 1);
        idle();
        cyc();
        chk("force_cleared_cs", last_cs, 0);
        drain(n);
        chk("force_avail_kept", n, 8);

        // Consume and pop in the same cycle keep the new pop
        do_reset();
        pops(3);
        qv = 1; qr = 1; cons = 1;
        cyc();
        idle();
        cyc();
        chk("consume_pop_cs", last_cs, 1);

        // Send and receive of two credits together at avail=5
        do_reset();
        dv = 1; dr = 1;
        repeat (3) cyc();
        rcv = 1; cr = 2;
        cyc();
        drain(n);
        chk("send_recv_avail", n, 6);

        // Asynchronous reset mid-transfer with avail=2, pend=3
        do_reset();
        dv = 1; dr = 1; qv = 1; qr = 1;
        repeat (3) cyc();
        qv = 0; qr = 0;
        repeat (3) cyc();
        allow = 1; dr = 0;
        rst_n = 0; m_avail = NC; m_pend = 0;
        #1;
        chk("async_reset_cs",  int'(cs), 0);
        chk("async_reset_cop", int'(cop), 0);
        cyc();
        rst_n = 1;
        drain(n);
        chk("async_reset_avail", n, 8);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit can, dsend;
            int limit;
            idle();
            dv = 1'($urandom); dr = 1'($urandom);
            qv = 1'($urandom); qr = 1'($urandom);
            allow = 1'($urandom); cons = ($urandom_range(0, 3) == 0);
            req = ($urandom_range(0, 7) != 0);
            can = (m_avail > 0) || !req;
            dsend = dv && can && dr && req;
            limit = NC - m_avail + (dsend ? 1 : 0);
            cr = bridge_credit_t'($urandom_range(0, 15));
            if (limit > 0 && $urandom_range(0, 3) == 0) begin
                rcv = 1;
                cr = bridge_credit_t'($urandom_range(1, limit));
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
